// File: rtl/image_window_streamer.sv
// image_window_streamer
// Captures the 30x30 binary image on an accepted start and streams every
// 3x3 window in raster order over a valid/ready handshake, one per cycle.
// All outputs are registers; win_ready only feeds next-state logic.

module image_window_streamer #(
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int TOTAL_BITS = 904,
  parameter int OUT_W      = 28,
  parameter int OUT_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  img_full,
  input  logic [TOTAL_BITS-1:0] img_in,
  input  logic                  abort,
  input  logic                  win_ready,
  output logic                  win_valid,
  output logic [8:0]            win_data,
  output logic [4:0]            win_row,
  output logic [4:0]            win_col,
  output logic                  win_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = $clog2(PIX);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [PIX-1:0]   snap_r, snap_s;
  logic [4:0]       row_r, row_s;
  logic [4:0]       col_r, col_s;
  logic             done_s;
  logic             valid_r, busy_r, last_r, done_r;
  logic [8:0]       data_r;
  logic [8:0]       data_s;
  logic             last_s;
  logic             in_scan_s;

  // Padding bits above the pixel area carry no information.
  logic             unused_pad_s;
  assign unused_pad_s = ^img_in[TOTAL_BITS-1:PIX];

  // Gathers the 3x3 neighbourhood whose top-left pixel is (r,c);
  // bit ky*3+kx holds pixel (r+ky, c+kx).
  function automatic logic [8:0] get_window(input logic [PIX-1:0] im,
                                            input logic [4:0]     r,
                                            input logic [4:0]     c);
    logic [IDX_W-1:0] base;
    logic [8:0]       w;
    base = IDX_W'(r) * IDX_W'(IMG_WIDTH) + IDX_W'(c);
    w    = 9'd0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        w[ky*3+kx] = im[base + IDX_W'(ky*IMG_WIDTH + kx)];
      end
    end
    return w;
  endfunction

  // Next-state logic: start acceptance, raster stepping, abort and completion.
  always_comb begin
    state_s = state_r;
    snap_s  = snap_r;
    row_s   = row_r;
    col_s   = col_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && img_full) begin
          state_s = SCAN;
          snap_s  = img_in[PIX-1:0];
          row_s   = 5'd0;
          col_s   = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          // Abort wins over a simultaneous transfer and never signals done.
          state_s = IDLE;
          row_s   = 5'd0;
          col_s   = 5'd0;
        end else if (win_ready) begin
          if (last_r) begin
            state_s = IDLE;
            row_s   = 5'd0;
            col_s   = 5'd0;
            done_s  = 1'b1;
          end else if (col_r == 5'(OUT_W-1)) begin
            col_s = 5'd0;
            row_s = row_r + 5'd1;
          end else begin
            col_s = col_r + 5'd1;
          end
        end else begin
          state_s = SCAN;
        end
      end
      default: begin
        state_s = IDLE;
        row_s   = 5'd0;
        col_s   = 5'd0;
      end
    endcase
  end

  // Next output values derived from the next state so outputs stay registered.
  always_comb begin
    in_scan_s = (state_s == SCAN);
    data_s    = in_scan_s ? get_window(snap_s, row_s, col_s) : 9'd0;
    last_s    = in_scan_s && (row_s == 5'(OUT_H-1)) && (col_s == 5'(OUT_W-1));
  end

  // FSM state, snapshot and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      snap_r  <= '0;
      row_r   <= 5'd0;
      col_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      snap_r  <= snap_s;
      row_r   <= row_s;
      col_r   <= col_s;
    end
  end

  // Registered window outputs and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      data_r  <= 9'd0;
    end else begin
      valid_r <= in_scan_s;
      busy_r  <= in_scan_s;
      last_r  <= last_s;
      done_r  <= done_s;
      data_r  <= data_s;
    end
  end

  assign win_valid = valid_r;
  assign win_data  = data_r;
  assign win_row   = row_r;
  assign win_col   = col_r;
  assign win_last  = last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_image_window_streamer.sv
// Directed bench for image_window_streamer: reference windows come from a
// copy of the image the bench keeps at start time.

module tb_image_window_streamer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         img_full;
  logic [903:0] img_in;
  logic         abort;
  logic         win_ready;
  logic         win_valid;
  logic [8:0]   win_data;
  logic [4:0]   win_row;
  logic [4:0]   win_col;
  logic         win_last;
  logic         busy;
  logic         done;

  int tests;
  int fails;

  image_window_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_full  (img_full),
    .img_in    (img_in),
    .abort     (abort),
    .win_ready (win_ready),
    .win_valid (win_valid),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_win(input logic [899:0] im, input int r, input int c);
    logic [8:0] w;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        w[ky*3+kx] = im[(r+ky)*30 + c + kx];
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 904; i += 8) img_in[i +: 8] = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(win_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_last"},  32'(win_last),  32'd0);
    chk({tag, "_data"},  32'(win_data),  32'd0);
    chk({tag, "_row"},   32'(win_row),   32'd0);
    chk({tag, "_col"},   32'(win_col),   32'd0);
  endtask

  // Starts a scan and follows it to done (or to an abort at window abort_idx).
  // At window poke_idx a second start is issued and img_in is inverted.
  task automatic run_scan(input bit rnd, input int abort_idx, input int poke_idx,
                          output logic [8:0] first_d, output logic [8:0] last_d,
                          output int nx);
    logic [899:0] ref_img;
    logic [8:0]   pd;
    logic [4:0]   pr, pc;
    int           k, cyc;
    bit           fin, stalled, ab, poked;
    ref_img = img_in[899:0];
    k = 0; cyc = 0; fin = 1'b0; poked = 1'b0;
    first_d = 9'd0; last_d = 9'd0;
    img_full = 1'b1; start = 1'b1; abort = 1'b0; win_ready = 1'b1;
    step();
    start = 1'b0; cyc = 1;
    while (!fin) begin
      if (cyc > 4000) begin
        chk("scan_timeout", 32'(cyc), 32'd0);
        fin = 1'b1;
      end else if (done) begin
        chk("done_count", 32'(k), 32'd784);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(win_valid), 32'd0);
        chk("done_last", 32'(win_last), 32'd0);
        if (!rnd) chk("done_cycle", 32'(cyc), 32'd785);
        fin = 1'b1;
      end else begin
        chk("valid", 32'(win_valid), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("row", 32'(win_row), 32'(k / 28));
        chk("col", 32'(win_col), 32'(k % 28));
        chk("data", 32'(win_data), 32'(ref_win(ref_img, k / 28, k % 28)));
        chk("last", 32'(win_last), 32'(k == 783));
        if (k == 0)   first_d = win_data;
        if (k == 783) last_d  = win_data;
        win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ab = (k == abort_idx);
        abort = ab;
        if (k == poke_idx && !poked) begin
          poked = 1'b1;
          start = 1'b1;
          img_in = ~img_in;
        end
        stalled = !win_ready;
        pd = win_data; pr = win_row; pc = win_col;
        step();
        cyc++;
        abort = 1'b0;
        start = 1'b0;
        if (ab) begin
          chk("abort_valid", 32'(win_valid), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_row", 32'(win_row), 32'd0);
          chk("abort_col", 32'(win_col), 32'd0);
          step();
          chk("abort_done_late", 32'(done), 32'd0);
          fin = 1'b1;
        end else if (stalled) begin
          chk("hold_data", 32'(win_data), 32'(pd));
          chk("hold_row", 32'(win_row), 32'(pr));
          chk("hold_col", 32'(win_col), 32'(pc));
        end else begin
          k++;
        end
      end
    end
    nx = k;
  endtask

  initial begin
    logic [8:0] fd, ld;
    int         nx, guard;
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; img_full = 1'b0; img_in = '0;
    abort = 1'b0; win_ready = 1'b0;
    #12;
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all_zero("after_reset");

    // abort in IDLE does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // start ignored when the buffer is not full
    img_full = 1'b0; start = 1'b1; win_ready = 1'b1;
    step();
    start = 1'b0;
    chk("nofull_busy", 32'(busy), 32'd0);
    chk("nofull_valid", 32'(win_valid), 32'd0);
    step();
    chk("nofull_busy2", 32'(busy), 32'd0);

    // unstalled scan: pixel(r,c) = c[0]
    for (int i = 0; i < 904; i++) img_in[i] = 1'((i % 30) & 1);
    run_scan(1'b0, -1, -1, fd, ld, nx);
    chk("alt_first", 32'(fd), 32'h092);
    chk("alt_last", 32'(ld), 32'h16D);
    chk("alt_count", 32'(nx), 32'd784);

    // backpressure on a random image, started on the done cycle
    fill_random();
    run_scan(1'b1, -1, -1, fd, ld, nx);
    chk("bp_count", 32'(nx), 32'd784);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // snapshot isolation: zero image, img_in flipped to ones right after start
    img_in = '0;
    run_scan(1'b0, -1, 0, fd, ld, nx);
    chk("iso_last", 32'(ld), 32'd0);
    chk("iso_count", 32'(nx), 32'd784);

    // start during SCAN is ignored
    fill_random();
    run_scan(1'b0, -1, 10, fd, ld, nx);
    chk("restart_count", 32'(nx), 32'd784);

    // abort at (5,12) with a transfer, then a fresh scan from (0,0)
    fill_random();
    run_scan(1'b0, 5*28+12, -1, fd, ld, nx);
    chk("abort_index", 32'(nx), 32'd152);
    run_scan(1'b0, -1, -1, fd, ld, nx);
    chk("post_abort_count", 32'(nx), 32'd784);

    // asynchronous reset at (14,3)
    fill_random();
    img_full = 1'b1; start = 1'b1; win_ready = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!(win_row == 5'd14 && win_col == 5'd3) && guard < 1000) begin
      step();
      guard++;
    end
    chk("reach_14_3", 32'(guard < 1000), 32'd1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // only pixel (29,29) and the padding bits set
    img_in = '0;
    img_in[899] = 1'b1;
    img_in[903:900] = 4'hF;
    run_scan(1'b0, -1, -1, fd, ld, nx);
    chk("corner_first", 32'(fd), 32'd0);
    chk("corner_last", 32'(ld), 32'h100);
    chk("corner_count", 32'(nx), 32'd784);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
